// File: rtl/acc_pkg.sv
// acc_pkg: shared opcode constants and FSM state encoding for the
// parametrised accumulator (acc_nbit) and its ALU (alu_nbit).
package acc_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
  localparam logic [OP_W-1:0] OP_AND  = 3'b010;
  localparam logic [OP_W-1:0] OP_OR   = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b100;
  localparam logic [OP_W-1:0] OP_LOAD = 3'b101;
  localparam logic [OP_W-1:0] OP_CLR  = 3'b110;
  localparam logic [OP_W-1:0] OP_PASS = 3'b111;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/acc_nbit_if.sv
// acc_nbit_if: operand input channel and result output channel of the
// accumulator, both valid/ready. slave = accumulator side, master = driver.
interface acc_nbit_if #(parameter int WIDTH = 8);
  import acc_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_op;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic             out_ovf;

  modport slave (
    input  in_valid, in_op, in_data, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_ovf
  );

  modport master (
    output in_valid, in_op, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_ovf
  );
endinterface

// File: rtl/alu_nbit.sv
// alu_nbit: combinational WIDTH-bit ALU for the accumulator.
// Optional build macro ACC_SAT_EN: ADD/SUB clamp unsigned instead of wrapping;
// carry/ovf always reflect the wrapped arithmetic.
module alu_nbit
  import acc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             ovf
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // Opcode decode; flags are only raised by ADD and SUB
  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    diff  = {1'b0, a} - {1'b0, b};
    y     = a;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op)
      OP_ADD: begin
        carry = sum[WIDTH];
        ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
`ifdef ACC_SAT_EN
        y = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
        y = sum[WIDTH-1:0];
`endif
      end
      OP_SUB: begin
        // The extra bit of the widened difference is the unsigned borrow
        carry = diff[WIDTH];
        ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
`ifdef ACC_SAT_EN
        y = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
`else
        y = diff[WIDTH-1:0];
`endif
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_LOAD: y = b;
      OP_CLR:  y = '0;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/acc_nbit.sv
// acc_nbit: accumulates BURST operand/opcode pairs through alu_nbit, then
// holds the result with sticky carry/overflow until the consumer takes it.
// Optional build macro ACC_SAT_EN (handled inside alu_nbit) saturates ADD/SUB.
module acc_nbit
  import acc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic      clk,
  input  logic      rst,
  acc_nbit_if.slave bus
);

  localparam int CNT_W = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST - 1);

  state_e           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic             carry_reg, carry_next;
  logic             ovf_reg, ovf_next;

  logic [WIDTH-1:0] alu_y;
  logic             alu_carry;
  logic             alu_ovf;

  alu_nbit #(.WIDTH(WIDTH)) u_alu (
    .a     (acc_reg),
    .b     (bus.in_data),
    .op    (bus.in_op),
    .y     (alu_y),
    .carry (alu_carry),
    .ovf   (alu_ovf)
  );

  // State, counter, accumulator and flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_ACC;
      cnt_reg   <= '0;
      acc_reg   <= '0;
      carry_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      acc_reg   <= acc_next;
      carry_reg <= carry_next;
      ovf_reg   <= ovf_next;
    end
  end

  // Next-state: fold operands while in ACC, release the result from HOLD
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    acc_next   = acc_reg;
    carry_next = carry_reg;
    ovf_next   = ovf_reg;
    case (state_reg)
      ST_ACC: begin
        if (bus.in_valid) begin
          acc_next   = alu_y;
          carry_next = carry_reg | alu_carry;
          ovf_next   = ovf_reg | alu_ovf;
          if (cnt_reg == CNT_LAST) begin
            cnt_next   = '0;
            state_next = ST_HOLD;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          acc_next   = '0;
          carry_next = 1'b0;
          ovf_next   = 1'b0;
          state_next = ST_ACC;
        end
      end
      default: state_next = ST_ACC;
    endcase
  end

  // Handshake outputs come straight from registered state
  assign bus.in_ready  = (state_reg == ST_ACC);
  assign bus.out_valid = (state_reg == ST_HOLD);
  assign bus.out_data  = acc_reg;
  assign bus.out_carry = carry_reg;
  assign bus.out_ovf   = ovf_reg;

endmodule

// File: tb/tb_acc_nbit.sv
// tb_acc_nbit: table-driven and randomized bursts for acc_nbit (WIDTH=8,
// BURST=4), checked against an integer-arithmetic reference model.
module tb_acc_nbit;
  import acc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  acc_nbit_if #(.WIDTH(8)) bus ();

  acc_nbit #(.WIDTH(8), .BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic [3:0][2:0] ops;
    logic [3:0][7:0] ds;
    logic [7:0]      exp_data;
    logic            exp_c;
    logic            exp_o;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: apply the opcode rules with plain integer arithmetic
  function automatic logic [9:0] ref_burst(input logic [3:0][2:0] ops, input logic [3:0][7:0] ds);
    int acc = 0;
    int c = 0;
    int o = 0;
    int b, r, sa, sb, sr;
    for (int i = 0; i < 4; i++) begin
      b  = int'(ds[i]);
      sa = (acc > 127) ? acc - 256 : acc;
      sb = (b > 127) ? b - 256 : b;
      case (ops[i])
        OP_ADD: begin
          r  = acc + b;
          sr = sa + sb;
          if (r > 255) c = 1;
          if (sr > 127 || sr < -128) o = 1;
`ifdef ACC_SAT_EN
          acc = (r > 255) ? 255 : r;
`else
          acc = r % 256;
`endif
        end
        OP_SUB: begin
          r  = acc - b;
          sr = sa - sb;
          if (acc < b) c = 1;
          if (sr > 127 || sr < -128) o = 1;
`ifdef ACC_SAT_EN
          acc = (r < 0) ? 0 : r;
`else
          acc = (r + 256) % 256;
`endif
        end
        OP_AND:  acc = acc & b;
        OP_OR:   acc = acc | b;
        OP_XOR:  acc = acc ^ b;
        OP_LOAD: acc = b;
        OP_CLR:  acc = 0;
        default: ;
      endcase
    end
    return {o[0], c[0], 8'(acc)};
  endfunction

  // Bounded wait for in_ready at a negedge
  task automatic wait_ready(input string name);
    int n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, " in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  // Present four operands back-to-back; entered and left on a negedge
  task automatic feed(input string name, input logic [3:0][2:0] ops, input logic [3:0][7:0] ds);
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_op    = ops[i];
      bus.in_data  = ds[i];
      wait_ready(name);
      check({name, " early_valid"}, 32'(bus.out_valid), 32'd0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_op    = 3'($urandom_range(0, 7));
    bus.in_data  = 8'($urandom);
  endtask

  task automatic check_result(input string name, input logic [9:0] exp);
    check({name, " out_valid"}, 32'(bus.out_valid), 32'd1);
    check({name, " out_data"},  32'(bus.out_data),  32'(exp[7:0]));
    check({name, " out_carry"}, 32'(bus.out_carry), 32'(exp[8]));
    check({name, " out_ovf"},   32'(bus.out_ovf),   32'(exp[9]));
    $display("burst %s: data=%0d carry=%0d ovf=%0d (exp %0d/%0d/%0d)", name,
             bus.out_data, bus.out_carry, bus.out_ovf, exp[7:0], exp[8], exp[9]);
  endtask

  task automatic handoff(input string name, input int gap);
    repeat (gap) begin
      @(negedge clk);
      check({name, " hold_valid"}, 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({name, " post_ready"}, 32'(bus.in_ready),  32'd1);
    check({name, " post_valid"}, 32'(bus.out_valid), 32'd0);
    check({name, " post_acc"},   32'(bus.out_data),  32'd0);
  endtask

  task automatic run_burst(input string name, input logic [3:0][2:0] ops,
                           input logic [3:0][7:0] ds, input logic [9:0] exp, input int gap);
    feed(name, ops, ds);
    check_result(name, exp);
    handoff(name, gap);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t            vecs[4];
    logic [3:0][2:0] rops;
    logic [3:0][7:0] rds;
    logic [7:0]      held;

    vecs[0] = '{"add4",  {OP_ADD, OP_ADD, OP_ADD, OP_ADD},
                {8'd40, 8'd30, 8'd20, 8'd10}, 8'd100, 1'b0, 1'b0};
    vecs[1] = '{"sticky", {OP_ADD, OP_LOAD, OP_ADD, OP_ADD},
                {8'd1, 8'd5, 8'd100, 8'd200}, 8'd6, 1'b1, 1'b0};
`ifdef ACC_SAT_EN
    vecs[2] = '{"borrow", {OP_PASS, OP_PASS, OP_SUB, OP_LOAD},
                {8'd0, 8'd0, 8'd1, 8'd0}, 8'd0, 1'b1, 1'b0};
`else
    vecs[2] = '{"borrow", {OP_PASS, OP_PASS, OP_SUB, OP_LOAD},
                {8'd0, 8'd0, 8'd1, 8'd0}, 8'd255, 1'b1, 1'b0};
`endif
    vecs[3] = '{"sovf",  {OP_OR, OP_AND, OP_ADD, OP_LOAD},
                {8'h00, 8'hFF, 8'd1, 8'd127}, 8'd128, 1'b0, 1'b1};

    bus.in_valid  = 1'b0;
    bus.in_op     = OP_ADD;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst in_ready",  32'(bus.in_ready),  32'd1);
    check("rst out_data",  32'(bus.out_data),  32'd0);
    check("rst out_carry", 32'(bus.out_carry), 32'd0);
    check("rst out_ovf",   32'(bus.out_ovf),   32'd0);

    // Directed table; the model must agree with the hand-derived answers too
    for (int i = 0; i < 4; i++) begin
      check({vecs[i].name, " model"}, 32'(ref_burst(vecs[i].ops, vecs[i].ds)),
            32'({vecs[i].exp_o, vecs[i].exp_c, vecs[i].exp_data}));
      run_burst(vecs[i].name, vecs[i].ops, vecs[i].ds,
                {vecs[i].exp_o, vecs[i].exp_c, vecs[i].exp_data}, 0);
    end

    // HOLD with in_valid asserted: result stable, nothing consumed
    feed("hold", {OP_ADD, OP_ADD, OP_ADD, OP_ADD}, {8'd4, 8'd3, 8'd2, 8'd1});
    check_result("hold", 10'd10);
    held = bus.out_data;
    bus.in_valid = 1'b1;
    bus.in_op    = OP_LOAD;
    bus.in_data  = 8'd99;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold valid",    32'(bus.out_valid), 32'd1);
      check("hold in_ready", 32'(bus.in_ready),  32'd0);
      check("hold data",     32'(bus.out_data),  32'(held));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("hold release ready", 32'(bus.in_ready), 32'd1);
    check("hold release acc",   32'(bus.out_data), 32'd0);
    bus.in_valid = 1'b0;
    run_burst("after_hold", {OP_ADD, OP_ADD, OP_ADD, OP_ADD},
              {8'd1, 8'd1, 8'd1, 8'd1}, 10'd4, 0);

    // Reset mid-burst discards the partial result
    bus.in_valid = 1'b1;
    bus.in_op    = OP_ADD;
    bus.in_data  = 8'd7;
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b0;
    check("pre_rst acc", 32'(bus.out_data), 32'd14);
    rst = 1'b1;
    #1;
    check("mid_rst out_data",  32'(bus.out_data),  32'd0);
    check("mid_rst in_ready",  32'(bus.in_ready),  32'd1);
    check("mid_rst out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_burst("after_rst", {OP_ADD, OP_ADD, OP_ADD, OP_ADD},
              {8'd1, 8'd1, 8'd1, 8'd1}, 10'd4, 0);

    // Randomized bursts with random consumer delay
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < 4; i++) begin
        rops[i] = 3'($urandom_range(0, 7));
        rds[i]  = 8'($urandom);
      end
      if (t % 3 == 0) rops[0] = OP_LOAD;
      run_burst($sformatf("rnd%0d", t), rops, rds, ref_burst(rops, rds),
                int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
